// File: rtl/cordic_pipe_param.sv
// cordic_pipe_param
//
// Pipelined two's-complement CORDIC engine with valid/ready flow control.
// One sample per cycle; each pipeline entry carries its own valid, mode and
// zero-vector flag, so rotation and vectoring samples can be mixed freely.
// Any stall at the output freezes the whole pipeline, valid bits included.
//
// Parameters
//   WIDTH   data width of x/y/z (signed)
//   FRAC    fractional bits of x/y/z (WIDTH-FRAC >= 3)
//   STAGES  number of micro-rotation stages (1..16)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low
//   in_valid   input sample present
//   in_ready   pipeline can accept (low only while an output is stalled)
//   op_mode    0 = rotation, 1 = vectoring
//   x_in/y_in  input coordinates
//   z_in       rotation angle in radians, [-pi, pi]; ignored in vectoring
//   out_valid  result present
//   out_ready  consumer accepts
//   out_mode   op_mode carried with the sample
//   x_out/y_out gain-compensated, saturated coordinates
//   z_out      rotation: residual angle; vectoring: atan2(y, x)
//
// Latency: a sample accepted at edge t shows out_valid at edge t+STAGES+1.

module cordic_pipe_param #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int STAGES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    // Two guard bits absorb the pre-rotation negation and the CORDIC gain.
    localparam int XW = WIDTH + 2;
    // Product of an XW-bit value and the (FRAC+2)-bit gain constant.
    localparam int PW = XW + FRAC + 2;

    function automatic real atan_real(input int i);
        case (i)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            default: return 0.000030517578115526096;
        endcase
    endfunction

    // Round a positive real constant to nearest at FRAC fractional bits.
    function automatic int round_frac(input real v);
        return $rtoi(v * (2.0 ** FRAC) + 0.5);
    endfunction

    localparam logic signed [WIDTH-1:0] PI_2     = WIDTH'(round_frac(1.5707963267948966));
    localparam logic signed [WIDTH-1:0] NEG_PI_2 = -PI_2;
    localparam logic signed [FRAC+1:0]  KC       = (FRAC+2)'(round_frac(0.6072529));
    localparam logic signed [PW-1:0]    HALF     = PW'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [PW-1:0]    MAX_OUT  = PW'((longint'(1) <<< (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0]    MIN_OUT  = -MAX_OUT - PW'(1);

    // Index 0 holds the pre-rotation result; index k holds micro stage k-1.
    logic                    valid_reg [0:STAGES];
    logic                    mode_reg  [0:STAGES];
    logic                    zero_reg  [0:STAGES];
    logic signed [XW-1:0]    x_reg     [0:STAGES];
    logic signed [XW-1:0]    y_reg     [0:STAGES];
    logic signed [WIDTH-1:0] z_reg     [0:STAGES];
    logic signed [XW-1:0]    x_next    [0:STAGES];
    logic signed [XW-1:0]    y_next    [0:STAGES];
    logic signed [WIDTH-1:0] z_next    [0:STAGES];

    logic                    advance;
    logic signed [XW-1:0]    x_ext;
    logic signed [XW-1:0]    y_ext;
    logic signed [XW-1:0]    pre_x_next;
    logic signed [XW-1:0]    pre_y_next;
    logic signed [WIDTH-1:0] pre_z_next;

    // The only stall source is a held result, so the whole pipe moves together.
    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

    // Quadrant pre-rotation brings the vector/angle into the CORDIC
    // convergence range of about +/-1.74 rad.
    always_comb begin
        pre_x_next = x_ext;
        pre_y_next = y_ext;
        pre_z_next = z_in;
        if (!op_mode) begin
            if (z_in > PI_2) begin
                pre_x_next = -y_ext;
                pre_y_next = x_ext;
                pre_z_next = z_in - PI_2;
            end else if (z_in < NEG_PI_2) begin
                pre_x_next = y_ext;
                pre_y_next = -x_ext;
                pre_z_next = z_in + PI_2;
            end
        end else begin
            pre_z_next = '0;
            if (x_in < 0) begin
                if (y_in >= 0) begin
                    pre_x_next = y_ext;
                    pre_y_next = -x_ext;
                    pre_z_next = PI_2;
                end else begin
                    pre_x_next = -y_ext;
                    pre_y_next = x_ext;
                    pre_z_next = NEG_PI_2;
                end
            end
        end
    end

    assign x_next[0] = pre_x_next;
    assign y_next[0] = pre_y_next;
    assign z_next[0] = pre_z_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic signed [WIDTH-1:0] ATAN_I = WIDTH'(round_frac(atan_real(gi)));
            logic                 d_pos;
            logic signed [XW-1:0] x_shift;
            logic signed [XW-1:0] y_shift;

            // Rotation drives z toward 0; vectoring drives y toward 0.
            assign d_pos   = mode_reg[gi] ? (y_reg[gi] < 0) : (z_reg[gi] >= 0);
            assign x_shift = x_reg[gi] >>> gi;
            assign y_shift = y_reg[gi] >>> gi;

            assign x_next[gi+1] = d_pos ? (x_reg[gi] - y_shift) : (x_reg[gi] + y_shift);
            assign y_next[gi+1] = d_pos ? (y_reg[gi] + x_shift) : (y_reg[gi] - x_shift);
            assign z_next[gi+1] = d_pos ? (z_reg[gi] - ATAN_I)  : (z_reg[gi] + ATAN_I);
        end
    endgenerate

    // Control chain: valid, mode and zero-vector flag travel with each entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                mode_reg[k]  <= 1'b0;
                zero_reg[k]  <= 1'b0;
            end
        end else if (advance) begin
            valid_reg[0] <= in_valid;
            mode_reg[0]  <= op_mode;
            // A null vector has no defined angle; its phase is reported as 0.
            zero_reg[0]  <= op_mode && (x_in == '0) && (y_in == '0);
            for (int k = 1; k <= STAGES; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                mode_reg[k]  <= mode_reg[k-1];
                zero_reg[k]  <= zero_reg[k-1];
            end
        end
    end

    // Datapath registers need no reset: their contents are qualified by valid.
    always_ff @(posedge clock) begin
        if (advance) begin
            for (int k = 0; k <= STAGES; k++) begin
                x_reg[k] <= x_next[k];
                y_reg[k] <= y_next[k];
                z_reg[k] <= z_next[k];
            end
        end
    end

    // Gain compensation with round-half-up and saturation to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] compensate(input logic signed [XW-1:0] v);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] scaled;
        prod   = PW'(v) * PW'(KC) + HALF;
        scaled = prod >>> FRAC;
        if (scaled > MAX_OUT) begin
            return MAX_OUT[WIDTH-1:0];
        end else if (scaled < MIN_OUT) begin
            return MIN_OUT[WIDTH-1:0];
        end
        return scaled[WIDTH-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (advance) begin
            out_valid <= valid_reg[STAGES];
            // Result registers only change when a real sample lands.
            if (valid_reg[STAGES]) begin
                out_mode <= mode_reg[STAGES];
                x_out    <= compensate(x_reg[STAGES]);
                y_out    <= compensate(y_reg[STAGES]);
                z_out    <= zero_reg[STAGES] ? '0 : z_reg[STAGES];
            end
        end
    end

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Testbench for cordic_pipe_param at WIDTH=16, FRAC=8, STAGES=8.
// A scoreboard holds the expected result of every accepted sample, computed
// by a plain sequential evaluation of the CORDIC rules; the output is
// checked against the queue head on every cycle out_valid is high.
// Directed checks with literal tolerances pin that model.

module tb_cordic_pipe_param;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               op_mode = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic signed [15:0] z_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_mode;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic signed [15:0] z_out;

    cordic_pipe_param #(.WIDTH(16), .FRAC(8), .STAGES(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_mode  (op_mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit m;
        int x;
        int y;
        int z;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   transfers = 0;

    function automatic int atan8(input int i);
        case (i)
            0: return 201;
            1: return 119;
            2: return 63;
            3: return 32;
            4: return 16;
            5: return 8;
            6: return 4;
            7: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int comp8(input int v);
        longint p;
        p = (longint'(v) * 155 + 128) >>> 8;
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
    endfunction

    // Expected result of one sample, evaluated sequentially from the rules.
    function automatic exp_t model(input bit m, input int x, input int y, input int z);
        exp_t r;
        int xa, ya, za, t, d;
        xa = x; ya = y; za = z;
        if (!m) begin
            if (z > 402) begin xa = -y; ya = x; za = z - 402; end
            else if (z < -402) begin xa = y; ya = -x; za = z + 402; end
        end else begin
            za = 0;
            if (x < 0 && y >= 0) begin xa = y; ya = -x; za = 402; end
            else if (x < 0) begin xa = -y; ya = x; za = -402; end
        end
        for (int i = 0; i < 8; i++) begin
            if (!m) d = (za >= 0) ? 1 : -1;
            else    d = (ya < 0) ? 1 : -1;
            t  = xa - d * (ya >>> i);
            ya = ya + d * (xa >>> i);
            xa = t;
            za = za - d * atan8(i);
        end
        r.m = m;
        r.x = comp8(xa);
        r.y = comp8(ya);
        r.z = (m && x == 0 && y == 0) ? 0 : za;
        return r;
    endfunction

    task automatic check(input string name, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input int act, input int req, input int tol);
        int diff;
        diff = act - req;
        if (diff < 0) diff = -diff;
        check(name, diff <= tol, act, req);
    endtask

    // Scoreboard bookkeeping on the active edge (pre-edge DUT values).
    always @(posedge clock) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                transfers++;
                $display("[TB] out #%0d mode=%0d x=%0d y=%0d z=%0d",
                         transfers, out_mode, x_out, y_out, z_out);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op_mode, int'(x_in), int'(y_in), int'(z_in)));
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (reset) begin
            check("in_ready", in_ready == !(out_valid && !out_ready), int'(in_ready),
                  int'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b0, int'(x_out), 0);
                end else begin
                    e = sb[0];
                    tests++;
                    if (out_mode != e.m || int'(x_out) != e.x || int'(y_out) != e.y
                        || int'(z_out) != e.z) begin
                        fails++;
                        $display("[TB] FAIL result: got m=%0d x=%0d y=%0d z=%0d, required m=%0d x=%0d y=%0d z=%0d",
                                 out_mode, x_out, y_out, z_out, e.m, e.x, e.y, e.z);
                    end
                end
            end
        end
    end

    // Send one sample into an idle pipe; returns at the negedge where
    // out_valid is first seen, lat = edges counted from the acceptance edge.
    task automatic run_one(input bit m, input int x, input int y, input int z, output int lat);
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_mode   = m;
        x_in      = 16'(x);
        y_in      = 16'(y);
        z_in      = 16'(z);
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        #3;
    endtask

    initial begin
        int lat, idx, cyc, stalls;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("rst_out_mode", out_mode == 1'b0, int'(out_mode), 0);
        check("rst_x_out", x_out == 0, int'(x_out), 0);
        check("rst_y_out", y_out == 0, int'(y_out), 0);
        check("rst_z_out", z_out == 0, int'(z_out), 0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);

        // Rotation by pi/2
        run_one(1'b0, 256, 0, 402, lat);
        check("rot_latency", lat == 10, lat, 10);
        check("rot_mode", out_mode == 1'b0, int'(out_mode), 0);
        check_near("rot_x", int'(x_out), 0, 3);
        check_near("rot_y", int'(y_out), 256, 3);

        // Vectoring, first and second quadrant
        run_one(1'b1, 256, 256, 0, lat);
        check("vec_latency", lat == 10, lat, 10);
        check("vec_mode", out_mode == 1'b1, int'(out_mode), 1);
        check_near("vec45_x", int'(x_out), 362, 3);
        check_near("vec45_z", int'(z_out), 201, 2);
        run_one(1'b1, -256, 0, 0, lat);
        check_near("vec180_x", int'(x_out), 256, 3);
        check_near("vec180_z", int'(z_out), 804, 2);

        // Saturation
        run_one(1'b1, 32767, 32767, 0, lat);
        check("sat_vec_x", int'(x_out) == 32767, int'(x_out), 32767);
        run_one(1'b0, 32767, 32767, 201, lat);
        check("sat_rot_y", int'(y_out) == 32767, int'(y_out), 32767);

        // Vectoring boundaries
        run_one(1'b1, -32768, 0, 0, lat);
        check("minx_x_positive", x_out > 0, int'(x_out), 32767);
        run_one(1'b1, 0, 0, 0, lat);
        check("zero_vec_z", z_out == 0, int'(z_out), 0);
        check("zero_vec_x", x_out == 0, int'(x_out), 0);

        // Stream of 20 alternating-mode samples with a 5-cycle output stall
        idx = 0; cyc = 0; stalls = 0;
        while ((idx < 20 || sb.size() > 0 || out_valid) && cyc < 300) begin
            @(negedge clock);
            out_ready = !(cyc >= 12 && cyc < 17);
            if (idx < 20) begin
                in_valid = 1'b1;
                op_mode  = idx[0];
                x_in     = 16'(idx * 300 - 3000);
                y_in     = 16'(2000 - idx * 250);
                z_in     = 16'(idx * 80 - 800);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) stalls++;
            @(posedge clock);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", idx == 20, idx, 20);
        check("stream_stalls", stalls == 5, stalls, 5);
        check("stream_drained", sb.size() == 0, sb.size(), 0);
        check("stream_transfers", transfers == 27, transfers, 27);

        // Reset with 5 samples in flight
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            op_mode  = i[0];
            x_in     = 16'(100 + i);
            y_in     = 16'(50 - i);
            z_in     = 16'(i * 30);
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("flush_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("flush_x_out", x_out == 0, int'(x_out), 0);
        check("flush_z_out", z_out == 0, int'(z_out), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("flush_quiet", out_valid == 1'b0, int'(out_valid), 0);
        end
        run_one(1'b0, 200, -100, -300, lat);
        check("post_rst_latency", lat == 10, lat, 10);
        repeat (3) @(negedge clock);
        check("total_transfers", transfers == 28, transfers, 28);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
